// File: rtl/v_nibble_packer.sv
// Packs a stream of 4-bit nibbles LSB-first into words of NIBBLES nibbles, with flush of partial words.
// Optional registered even parity on out_par when V_NIBBLE_PACKER_PARITY_EN is defined.
module v_nibble_packer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [3:0]             in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic [3:0]             out_nib,
    output logic                   out_par
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    logic [CW-1:0] cnt_r;
    logic [W-1:0]  acc_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic [3:0]    out_nib_r;

    logic          slot_free_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          complete_s;
    logic          flush_ok_s;
    logic [W-1:0]  merged_s;
    logic [3:0]    fill_s;

    logic [CW-1:0] cnt_s;
    logic [W-1:0]  acc_s;
    logic          valid_s;
    logic [W-1:0]  data_s;
    logic [3:0]    nib_s;

    // Handshake qualification and the accumulator with this cycle's nibble merged in
    always_comb begin
        slot_free_s = !out_valid_r || out_ready;
        // Only the completing nibble needs the output slot; earlier nibbles go to the accumulator
        in_ready_s  = slot_free_s || (cnt_r != CNT_LAST);
        accept_s    = in_valid && in_ready_s;
        complete_s  = accept_s && (cnt_r == CNT_LAST);
        flush_ok_s  = flush && slot_free_s && ((cnt_r != {CW{1'b0}}) || accept_s);
        fill_s      = 4'(cnt_r) + {3'b000, accept_s};
        merged_s    = acc_r;
        for (int k = 0; k < NIBBLES; k++) begin
            if (accept_s && (cnt_r == CW'(k))) begin
                merged_s[4*k +: 4] = in_data;
            end else begin
                merged_s[4*k +: 4] = acc_r[4*k +: 4];
            end
        end
    end

    // Next-state: load a full or flushed word, otherwise accumulate and drain
    always_comb begin
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        valid_s = out_valid_r;
        data_s  = out_data_r;
        nib_s   = out_nib_r;
        if (complete_s || flush_ok_s) begin
            data_s  = merged_s;
            nib_s   = fill_s;
            valid_s = 1'b1;
            cnt_s   = {CW{1'b0}};
            acc_s   = {W{1'b0}};
        end else begin
            if (accept_s) begin
                acc_s = merged_s;
                cnt_s = cnt_r + CW'(1);
            end else begin
                acc_s = acc_r;
                cnt_s = cnt_r;
            end
            if (out_valid_r && out_ready) begin
                valid_s = 1'b0;
            end else begin
                valid_s = out_valid_r;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_nib_r   <= 4'd0;
        end else begin
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            out_valid_r <= valid_s;
            out_data_r  <= data_s;
            out_nib_r   <= nib_s;
        end
    end

`ifdef V_NIBBLE_PACKER_PARITY_EN
    logic par_r;

    function automatic logic even_parity(input logic [W-1:0] d);
        return ^d;
    endfunction

    // Parity follows the word into the output register on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
        end else if (complete_s || flush_ok_s) begin
            par_r <= even_parity(merged_s);
        end else begin
            par_r <= par_r;
        end
    end

    assign out_par = par_r;
`else
    assign out_par = 1'b0;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_nib   = out_nib_r;

endmodule

// File: tb/tb_v_nibble_packer.sv
// Directed self-checking bench for v_nibble_packer with NIBBLES=4.
module tb_v_nibble_packer;

`ifdef V_NIBBLE_PACKER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_nib;
    logic        out_par;

    int checks;
    int passes;

    v_nibble_packer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nib   (out_nib),
        .out_par   (out_par)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] n);
        in_valid = 1'b1;
        in_data  = n;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", out_data); else passes++;
        checks++; if (out_nib !== 4'd0) $display("FAIL reset_nib: got %0d expected 0", out_nib); else passes++;
        checks++; if (out_par !== 1'b0) $display("FAIL reset_par: got %b expected 0", out_par); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else passes++;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(4'h1); send(4'hB); send(4'h2);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else passes++;
        send(4'h3);
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_data !== 16'h32B1) $display("FAIL basic_data: got %h expected 32b1", out_data); else passes++;
        checks++; if (out_nib !== 4'd4) $display("FAIL basic_nib: got %0d expected 4", out_nib); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b expected 0", out_valid); else passes++;
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_empty_noop: got %b expected 0", out_valid); else passes++;
        send(4'hA); send(4'h5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL flush_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_data !== 16'h005A) $display("FAIL flush_data: got %h expected 005a", out_data); else passes++;
        checks++; if (out_nib !== 4'd2) $display("FAIL flush_nib: got %0d expected 2", out_nib); else passes++;
        tick();
        send(4'h1); send(4'h2); send(4'h3);
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_cnt_cleared: got %b expected 0", out_valid); else passes++;
        send(4'h4);
        checks++; if (out_data !== 16'h4321) $display("FAIL flush_next_word: got %h expected 4321", out_data); else passes++;
        tick();
        in_valid = 1'b1; in_data = 4'h7; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_data !== 16'h0007) $display("FAIL flush_with_nibble_data: got %h expected 0007", out_data); else passes++;
        checks++; if (out_nib !== 4'd1) $display("FAIL flush_with_nibble_nib: got %0d expected 1", out_nib); else passes++;
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        checks++; if (out_data !== 16'h4321) $display("FAIL bp_word1: got %h expected 4321", out_data); else passes++;
        send(4'h5); send(4'h6); send(4'h7);
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b expected 1", out_valid); else passes++;
        in_valid = 1'b1; in_data = 4'h8; flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); else passes++;
        tick();
        checks++; if (out_data !== 16'h4321) $display("FAIL bp_hold_data: got %h expected 4321", out_data); else passes++;
        checks++; if (out_nib !== 4'd4) $display("FAIL bp_hold_nib: got %0d expected 4", out_nib); else passes++;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_rise: got %b expected 1", in_ready); else passes++;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_no_gap: got %b expected 1", out_valid); else passes++;
        checks++; if (out_data !== 16'h8765) $display("FAIL bp_word2: got %h expected 8765", out_data); else passes++;
        checks++; if (out_nib !== 4'd4) $display("FAIL bp_word2_nib: got %0d expected 4", out_nib); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_extra_flush_word: got %b expected 0", out_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        logic [3:0]  n;
        exp = 16'h0000;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n = 4'(i + 1);
            in_data = n;
            exp[4*(i%4) +: 4] = n;
            tick();
            if ((i % 4) == 3) begin
                checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b expected 1", i, out_valid); else passes++;
                checks++; if (out_data !== exp) $display("FAIL b2b_data_%0d: got %h expected %h", i, out_data, exp); else passes++;
            end else if ((i % 4) == 0 && i > 0) begin
                checks++; if (out_valid !== 1'b0) $display("FAIL b2b_gap_%0d: got %b expected 0", i, out_valid); else passes++;
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(4'hF); send(4'hE); send(4'hD); send(4'hC);
        send(4'h9); send(4'h9); send(4'h9);
        checks++; if (out_data !== 16'hCDEF) $display("FAIL rstmid_pre_data: got %h expected cdef", out_data); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_data !== 16'h0000) $display("FAIL rstmid_data: got %h expected 0000", out_data); else passes++;
        checks++; if (out_nib !== 4'd0) $display("FAIL rstmid_nib: got %0d expected 0", out_nib); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'h4);
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_partial_discarded: got %b expected 0", out_valid); else passes++;
        send(4'h3); send(4'h2); send(4'h1);
        checks++; if (out_data !== 16'h1234) $display("FAIL rstmid_word: got %h expected 1234", out_data); else passes++;
        checks++; if (out_par !== PAR_EN) $display("FAIL rstmid_par: got %b expected %b", out_par, PAR_EN); else passes++;
        tick();
    endtask

    task automatic test_parity;
        out_ready = 1'b1;
        send(4'h1); send(4'h0); send(4'h0); send(4'h0);
        checks++; if (out_data !== 16'h0001) $display("FAIL par_word1: got %h expected 0001", out_data); else passes++;
        checks++; if (out_par !== PAR_EN) $display("FAIL par_odd: got %b expected %b", out_par, PAR_EN); else passes++;
        send(4'h3); send(4'h0); send(4'h0); send(4'h0);
        checks++; if (out_data !== 16'h0003) $display("FAIL par_word2: got %h expected 0003", out_data); else passes++;
        checks++; if (out_par !== 1'b0) $display("FAIL par_even: got %b expected 0", out_par); else passes++;
        tick();
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
